// File: rtl/clm_rand_vect_gen_if.sv
// Request/vector bundle between an AES core (master) and its randomness source (slave).
// Master drives seeding and vector requests; slave returns the active vector and status.
interface clm_rand_vect_gen_if #(
  parameter int NUM_VECT = 23,
  parameter int POLY_W   = 7,
  parameter int P_DET_W  = 5,
  parameter int LFSR_W   = 32
);
  logic                       seed_we;
  logic [LFSR_W-1:0]          seed;
  logic                       req;
  logic [NUM_VECT*POLY_W-1:0] random_vect;
  logic [P_DET_W-1:0]         p_det;
  logic                       vect_vld;
  logic                       busy;
  logic                       underflow;

  modport master (
    output seed_we, seed, req,
    input  random_vect, p_det, vect_vld, busy, underflow
  );

  modport slave (
    input  seed_we, seed, req,
    output random_vect, p_det, vect_vld, busy, underflow
  );
endinterface

// File: rtl/clm_rand_vect_gen.sv
// Random red_poly vector + p_det source: Galois LFSR fills a shadow buffer in >= NUM_VECT+1 cycles.
// A request swaps shadow->active in one cycle; a request with no full shadow pulses underflow and is held pending.
module clm_rand_vect_gen #(
  parameter int                 NUM_VECT   = 23,
  parameter int                 POLY_W     = 7,
  parameter int                 P_DET_W    = 5,
  parameter logic [P_DET_W-1:0] P_DET_MIN  = P_DET_W'(1),
  parameter logic [P_DET_W-1:0] P_DET_MAX  = P_DET_W'(31),
  parameter bit                 NONZERO    = 1'b1,
  parameter int                 LFSR_W     = 32,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS  = LFSR_W'(32'h80200003),
  parameter logic [LFSR_W-1:0]  LFSR_RESET = LFSR_W'(1)
) (
  input  logic                clk,
  input  logic                rst_n,
  clm_rand_vect_gen_if.slave  bus
);

  localparam int              IDX_W    = (NUM_VECT > 1) ? $clog2(NUM_VECT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECT - 1);

  typedef enum logic [1:0] {ST_FILL, ST_PDET, ST_IDLE} state_t;

  state_t                     state, state_nxt;
  logic [LFSR_W-1:0]          lfsr, lfsr_step;
  logic [IDX_W-1:0]           idx;
  logic [NUM_VECT*POLY_W-1:0] shadow_vect, act_vect;
  logic [P_DET_W-1:0]         shadow_p_det, act_p_det;
  logic                       shadow_full, pending, underflow, vld;
  logic [POLY_W-1:0]          poly_sample;
  logic [P_DET_W-1:0]         pdet_sample;
  logic                       poly_ok, pdet_ok, swap;
  logic                       lfsr_run, fill_wr, pdet_wr;

  // Right-shifting Galois form: mask bit k carries the x^(k+1) term.
  assign lfsr_step   = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  assign poly_sample = lfsr_step[POLY_W-1:0];
  assign pdet_sample = lfsr_step[P_DET_W-1:0];
  assign poly_ok     = !NONZERO || (poly_sample != '0);
  assign pdet_ok     = (pdet_sample >= P_DET_MIN) && (pdet_sample <= P_DET_MAX);
  // A reseed in the same cycle invalidates the shadow, so it must block the swap.
  assign swap        = (bus.req || pending) && shadow_full && !bus.seed_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lfsr_run  = 1'b0;
    fill_wr   = 1'b0;
    pdet_wr   = 1'b0;
    case (state)
      ST_FILL: begin
        lfsr_run = 1'b1;
        if (poly_ok) begin
          fill_wr = 1'b1;
          if (idx == LAST_IDX) state_nxt = ST_PDET;
        end
      end
      ST_PDET: begin
        lfsr_run = 1'b1;
        if (pdet_ok) begin
          pdet_wr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        // Coming out of reset the shadow is empty, so IDLE immediately starts a fill.
        if (!shadow_full || swap) state_nxt = ST_FILL;
      end
    endcase
    if (bus.seed_we) state_nxt = ST_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr         <= LFSR_RESET;
      idx          <= '0;
      shadow_vect  <= '0;
      shadow_p_det <= '0;
      shadow_full  <= 1'b0;
      pending      <= 1'b0;
      underflow    <= 1'b0;
      vld          <= 1'b0;
      act_vect     <= '0;
      act_p_det    <= '0;
    end else begin
      underflow <= bus.req && !swap;

      if (bus.seed_we)   lfsr <= (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
      else if (lfsr_run) lfsr <= lfsr_step;

      if (bus.seed_we || swap) idx <= '0;
      else if (fill_wr)        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);

      for (int k = 0; k < NUM_VECT; k++) begin
        if (fill_wr && idx == IDX_W'(k)) shadow_vect[k*POLY_W +: POLY_W] <= poly_sample;
      end
      if (pdet_wr) shadow_p_det <= pdet_sample;

      if (bus.seed_we || swap) shadow_full <= 1'b0;
      else if (pdet_wr)        shadow_full <= 1'b1;

      if (swap)         pending <= 1'b0;
      else if (bus.req) pending <= 1'b1;

      if (swap) begin
        vld       <= 1'b1;
        act_vect  <= shadow_vect;
        act_p_det <= shadow_p_det;
      end else if (bus.req) begin
        vld <= 1'b0;
      end
    end
  end

  assign bus.random_vect = act_vect;
  assign bus.p_det       = act_p_det;
  assign bus.vect_vld    = vld;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.underflow   = underflow;

endmodule

// File: tb/tb_clm_rand_vect_gen.sv
// Directed bench for clm_rand_vect_gen: golden Galois model feeds a scoreboard of expected vectors.
module tb_clm_rand_vect_gen;

  typedef struct packed {
    logic [160:0] v;
    logic [4:0]   p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clm_rand_vect_gen_if #(.NUM_VECT(23), .POLY_W(7), .P_DET_W(5), .LFSR_W(32)) ifa ();
  clm_rand_vect_gen_if #(.NUM_VECT(23), .POLY_W(2), .P_DET_W(5), .LFSR_W(32)) ifb ();

  clm_rand_vect_gen #(.POLY_W(7), .P_DET_MIN(5'd11), .P_DET_MAX(5'd11)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );
  clm_rand_vect_gen #(.POLY_W(2), .P_DET_MIN(5'd4), .P_DET_MAX(5'd20)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last_a;

  task automatic check(input string tag, input logic [160:0] obs, input logic [160:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x^32+x^22+x^2+x+1, expressed as explicit feedback into bits 31, 21, 1, 0.
  function automatic logic [31:0] gal(input logic [31:0] s);
    logic [31:0] n;
    n     = s >> 1;
    n[31] = s[0];
    n[21] = s[22] ^ s[0];
    n[1]  = s[2] ^ s[0];
    n[0]  = s[1] ^ s[0];
    return n;
  endfunction

  task automatic model_fill(input int pw, input int pmin, input int pmax, input logic [31:0] s_in,
                            output logic [31:0] s_out, output exp_t x, output int steps, output int c10);
    logic [31:0] s;
    logic [31:0] smp;
    int k;
    s = s_in; k = 0; steps = 0; c10 = 0; x = '0;
    while (k < 23 && steps < 100000) begin
      s = gal(s);
      steps++;
      smp = s & ((32'd1 << pw) - 1);
      if (smp != 0) begin
        for (int b = 0; b < pw; b++) x.v[k*pw+b] = s[b];
        k++;
        if (k == 10) c10 = steps;
      end
    end
    do begin
      s = gal(s);
      steps++;
    end while (!(int'(s[4:0]) >= pmin && int'(s[4:0]) <= pmax) && steps < 100000);
    x.p   = s[4:0];
    s_out = s;
  endtask

  function automatic int zero_entries(input logic [160:0] v, input int pw);
    int z = 0;
    logic [160:0] t;
    for (int k = 0; k < 23; k++) begin
      t = v >> (k*pw);
      if ((t & ((161'd1 << pw) - 1)) == 0) z++;
    end
    return z;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pop_cmp_a(input string tag);
    exp_t x;
    x = sb.pop_front();
    check({tag, "_vect"}, 161'(ifa.random_vect), x.v);
    check({tag, "_pdet"}, 161'(ifa.p_det), 161'(x.p));
    last_a = x;
  endtask

  initial begin
    logic [31:0] ma, mb, mdummy;
    exp_t e, ed, x;
    int n, nd, c10, cd, cnt;

    ifa.seed_we = 1'b0; ifa.seed = '0; ifa.req = 1'b0;
    ifb.seed_we = 1'b0; ifb.seed = '0; ifb.req = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_vect",  161'(ifa.random_vect), 161'(0));
    check("rst_pdet",  161'(ifa.p_det), 161'(0));
    check("rst_vld",   161'(ifa.vect_vld), 161'(0));
    check("rst_busy",  161'(ifa.busy), 161'(0));
    check("rst_uflow", 161'(ifa.underflow), 161'(0));

    // Reset release, first fill from LFSR=1.
    rst_n = 1'b1;
    ma = 32'h1;
    model_fill(7, 11, 11, ma, ma, e, n, c10);
    cyc();
    check("busy_after_release", 161'(ifa.busy), 161'(1));
    cnt = 1;
    while (ifa.busy && cnt < 5000) begin cyc(); cnt++; end
    check("first_fill_latency", 161'(cnt), 161'(n + 1));
    check("vld_before_req", 161'(ifa.vect_vld), 161'(0));

    // Immediate swap.
    sb.push_back(e);
    ifa.req = 1'b1; cyc(); ifa.req = 1'b0;
    check("t2_vld",   161'(ifa.vect_vld), 161'(1));
    check("t2_uflow", 161'(ifa.underflow), 161'(0));
    pop_cmp_a("t2");
    check("t2_nonzero", 161'(zero_entries(161'(ifa.random_vect), 7)), 161'(0));
    check("t2_busy_refill", 161'(ifa.busy), 161'(1));

    // Request mid-fill: underflow, pending swap after shadow fills.
    model_fill(7, 11, 11, ma, ma, e, n, c10);
    repeat (4) cyc();
    sb.push_back(e);
    ifa.req = 1'b1; cyc(); ifa.req = 1'b0;
    check("t3_uflow",     161'(ifa.underflow), 161'(1));
    check("t3_vld_low",   161'(ifa.vect_vld), 161'(0));
    check("t3_active_kept", 161'(ifa.random_vect), last_a.v);
    cyc();
    check("t3_uflow_pulse", 161'(ifa.underflow), 161'(0));
    cnt = 0;
    while (!ifa.vect_vld && cnt < 5000) begin cyc(); cnt++; end
    check("t3_swap_delay", 161'(cnt), 161'(n - 5));
    pop_cmp_a("t3");

    // Reseed at idx=10 of the running fill.
    model_fill(7, 11, 11, ma, mdummy, ed, nd, c10);
    repeat (c10) cyc();
    ifa.seed_we = 1'b1; ifa.seed = 32'hDEADBEEF; cyc(); ifa.seed_we = 1'b0;
    check("t4_vld_kept",    161'(ifa.vect_vld), 161'(1));
    check("t4_active_kept", 161'(ifa.random_vect), last_a.v);
    ma = 32'hDEADBEEF;
    model_fill(7, 11, 11, ma, ma, e, n, cd);
    cnt = 0;
    while (ifa.busy && cnt < 5000) begin cyc(); cnt++; end
    check("t4_fill_latency", 161'(cnt), 161'(n));
    check("t4_active_still", 161'(ifa.random_vect), last_a.v);
    sb.push_back(e);
    ifa.req = 1'b1; cyc(); ifa.req = 1'b0;
    check("t4_vld", 161'(ifa.vect_vld), 161'(1));
    pop_cmp_a("t4");

    // Seed (value 0, loaded as 1) and request together with shadow full.
    model_fill(7, 11, 11, ma, ma, e, n, cd);
    cnt = 0;
    while (ifa.busy && cnt < 5000) begin cyc(); cnt++; end
    check("t5_fill_latency", 161'(cnt), 161'(n));
    ma = 32'h1;
    model_fill(7, 11, 11, ma, ma, e, n, cd);
    sb.push_back(e);
    ifa.seed_we = 1'b1; ifa.seed = 32'h0; ifa.req = 1'b1; cyc();
    ifa.seed_we = 1'b0; ifa.req = 1'b0;
    check("t5_uflow",       161'(ifa.underflow), 161'(1));
    check("t5_vld_low",     161'(ifa.vect_vld), 161'(0));
    check("t5_active_kept", 161'(ifa.random_vect), last_a.v);
    repeat (2) cyc();
    ifa.req = 1'b1; cyc(); ifa.req = 1'b0;
    check("t5_second_uflow", 161'(ifa.underflow), 161'(1));
    cnt = 0;
    while (!ifa.vect_vld && cnt < 5000) begin cyc(); cnt++; end
    check("t5_swap_delay", 161'(cnt), 161'(n - 2));
    pop_cmp_a("t5");

    // Pending requests must not queue a second swap.
    model_fill(7, 11, 11, ma, ma, e, n, cd);
    cnt = 0;
    while (ifa.busy && cnt < 5000) begin cyc(); cnt++; end
    check("t5b_fill_latency", 161'(cnt), 161'(n));
    repeat (3) cyc();
    check("t5b_no_second_swap", 161'(ifa.random_vect), last_a.v);
    check("t5b_vld", 161'(ifa.vect_vld), 161'(1));

    // Swap, then reset in the middle of the next fill.
    sb.push_back(e);
    ifa.req = 1'b1; cyc(); ifa.req = 1'b0;
    pop_cmp_a("t6");
    repeat (10) cyc();
    rst_n = 1'b0;
    #1;
    check("midrst_vect", 161'(ifa.random_vect), 161'(0));
    check("midrst_vld",  161'(ifa.vect_vld), 161'(0));
    check("midrst_busy", 161'(ifa.busy), 161'(0));
    cyc();
    rst_n = 1'b1;
    ma = 32'h1;
    model_fill(7, 11, 11, ma, ma, e, n, cd);
    cyc();
    cnt = 1;
    while (ifa.busy && cnt < 5000) begin cyc(); cnt++; end
    check("midrst_fill_latency", 161'(cnt), 161'(n + 1));
    check("midrst_vld_low", 161'(ifa.vect_vld), 161'(0));
    sb.push_back(e);
    ifa.req = 1'b1; cyc(); ifa.req = 1'b0;
    pop_cmp_a("midrst");

    // Narrow entries, many requests: model match, no zero entries, p_det in range.
    mb = 32'h1;
    for (int i = 0; i < 1000; i++) begin
      model_fill(2, 4, 20, mb, mb, e, n, cd);
      cnt = 0;
      while (ifb.busy && cnt < 1000) begin cyc(); cnt++; end
      sb.push_back(e);
      ifb.req = 1'b1; cyc(); ifb.req = 1'b0;
      x = sb.pop_front();
      check("b_vld",   161'(ifb.vect_vld), 161'(1));
      check("b_vect",  161'(ifb.random_vect), x.v);
      check("b_pdet",  161'(ifb.p_det), 161'(x.p));
      check("b_nonzero", 161'(zero_entries(161'(ifb.random_vect), 2)), 161'(0));
      check("b_pdet_range", 161'((ifb.p_det >= 5'd4) && (ifb.p_det <= 5'd20)), 161'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
